// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and pointer helper for the SYNFIFO read path
package fifo_pkg;
    localparam int FIFO_WIDTH      = 16;
    localparam int FIFO_SKID_DEPTH = 3;
    localparam int FIFO_CNT_W      = 16;
    localparam int PTR_FN_W        = 8;

    // Wrapping increment for circular buffers whose depth need not be a power of 2
    function automatic logic [PTR_FN_W-1:0] ptr_inc(input logic [PTR_FN_W-1:0] ptr,
                                                    input logic [PTR_FN_W-1:0] depth);
        return (ptr >= depth - PTR_FN_W'(1)) ? '0 : ptr + PTR_FN_W'(1);
    endfunction
endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - SKID_DEPTH x WIDTH circular register buffer with occupancy
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int  WIDTH      = FIFO_WIDTH,
    parameter int  SKID_DEPTH = FIFO_SKID_DEPTH,
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1),
    localparam int PTR_W      = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [OCC_W-1:0] occ
);
    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= PTR_W'(ptr_inc(PTR_FN_W'(wr_ptr), PTR_FN_W'(SKID_DEPTH)));
            end
            if (rd_en) begin
                rd_ptr <= PTR_W'(ptr_inc(PTR_FN_W'(rd_ptr), PTR_FN_W'(SKID_DEPTH)));
            end
            occ <= occ + OCC_W'(wr_en) - OCC_W'(rd_en);
        end
    end

    // Storage needs no reset: occ gates every read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = (occ != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/fifo_rd_streamer.sv
// rtl/fifo_rd_streamer.sv - SYNFIFO read master presenting a valid/ready stream
module fifo_rd_streamer
    import fifo_pkg::*;
#(
    parameter int WIDTH      = FIFO_WIDTH,
    parameter int SKID_DEPTH = FIFO_SKID_DEPTH,
    parameter int CNT_W      = FIFO_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic             f_rpop,
    input  logic             f_rempty,
    input  logic [WIDTH-1:0] f_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_cnt,
    output logic             idle
);
    localparam int OCC_W = $clog2(SKID_DEPTH + 1);
    localparam int CMT_W = OCC_W + 1;

    logic             inflight;
    logic             fire;
    logic [OCC_W-1:0] occ;
    logic [CMT_W-1:0] committed;

    // Words already owned by this block: buffered plus the one returning from RAM
    assign committed = {1'b0, occ} + CMT_W'(inflight);
    assign f_rpop    = !f_rempty && !flush && (committed < CMT_W'(SKID_DEPTH));
    assign out_valid = (occ != '0);
    assign fire      = out_valid && out_ready;
    assign idle      = f_rempty && (occ == '0) && !inflight;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            inflight <= 1'b0;
            out_cnt  <= '0;
        end else begin
            inflight <= f_rpop;
            if (fire) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end
        end
    end

    rd_skid_buf #(
        .WIDTH      (WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (inflight),
        .wr_data (f_rdata),
        .rd_en   (fire),
        .rd_data (out_data),
        .occ     (occ)
    );
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb/tb_fifo_rd_streamer.sv - self-checking bench for fifo_rd_streamer with a behavioural SYNFIFO
module tb_fifo_rd_streamer;
    localparam int W      = 16;
    localparam int FDEPTH = 8;
    localparam int SKID   = 3;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         flush     = 1'b0;
    logic         out_ready = 1'b0;
    logic         wpush     = 1'b0;
    logic [W-1:0] wdata     = '0;
    logic         f_rempty  = 1'b1;
    logic [W-1:0] f_rdata   = '0;
    logic         f_rpop;
    logic         out_valid;
    logic         idle;
    logic [W-1:0] out_data;
    logic [15:0]  out_cnt;

    always #5 clk = ~clk;

    fifo_rd_streamer #(.WIDTH(W), .SKID_DEPTH(SKID), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .f_rpop(f_rpop), .f_rempty(f_rempty), .f_rdata(f_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_cnt(out_cnt), .idle(idle)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Behavioural SYNFIFO: rdata registered one cycle after rpop
    logic [W-1:0] fq[$];
    always @(posedge clk) begin
        if (!rst_n) begin
            fq.delete();
            f_rdata  <= '0;
            f_rempty <= 1'b1;
        end else begin
            if (f_rpop && fq.size() != 0) f_rdata <= fq.pop_front();
            if (wpush && fq.size() < FDEPTH) fq.push_back(wdata);
            f_rempty <= (fq.size() == 0);
        end
    end

    // Reference model: words owned by the streamer, each visible from a given edge on
    typedef struct { logic [W-1:0] w; int avail; } ent_t;
    logic [W-1:0] mq[$];
    ent_t         pend[$];
    int           edge_n = 0;
    logic [15:0]  m_cnt  = '0;

    function automatic logic m_valid();
        if (pend.size() == 0) return 1'b0;
        return pend[0].avail <= edge_n;
    endfunction

    always @(posedge clk) begin
        logic fire_m;
        logic pop_m;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            pend.delete();
            m_cnt = '0;
        end else begin
            fire_m = m_valid() && out_ready;
            pop_m  = mq.size() != 0 && !flush && pend.size() < SKID;
            if (flush) begin
                pend.delete();
                m_cnt = '0;
            end else begin
                if (fire_m) begin
                    void'(pend.pop_front());
                    m_cnt = m_cnt + 16'd1;
                end
                if (pop_m) begin
                    e.w     = mq.pop_front();
                    e.avail = edge_n + 2;
                    pend.push_back(e);
                end
            end
            if (wpush && mq.size() < FDEPTH) mq.push_back(wdata);
        end
        edge_n++;
    end

    bit           chk_en      = 0;
    int           cyc         = 0;
    int           pops        = 0;
    int           first_pop   = -1;
    int           first_valid = -1;
    logic [W-1:0] fired[$];
    logic         hold_prev   = 1'b0;
    logic [W-1:0] hold_data   = '0;

    always @(negedge clk) begin
        logic [W-1:0] md;
        if (chk_en) begin
            md = m_valid() ? pend[0].w : '0;
            check("f_rpop", 32'(f_rpop), 32'(mq.size() != 0 && !flush && pend.size() < SKID));
            check("out_valid", 32'(out_valid), 32'(m_valid()));
            check("out_data", 32'(out_data), 32'(md));
            check("out_cnt", 32'(out_cnt), 32'(m_cnt));
            check("idle", 32'(idle), 32'(mq.size() == 0 && pend.size() == 0));
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_data));
            end
            hold_prev = out_valid && !out_ready && !flush && rst_n;
            hold_data = out_data;
            if (f_rpop) begin
                pops++;
                if (first_pop < 0) first_pop = cyc;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) fired.push_back(out_data);
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        pops = 0;
        first_pop = -1;
        first_valid = -1;
        fired.delete();
    endtask

    // Loads n words into the FIFO while flush holds the streamer empty; flush is left asserted
    task automatic fill(input logic [W-1:0] base, input int n);
        flush = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            wpush = 1'b1;
            wdata = base + W'(i);
            tick();
        end
        wpush = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            sample();
            if (idle) break;
            tick();
            out_ready = out_ready;
        end
        check({name, "_idle"}, 32'(idle), 32'd1);
    endtask

    task automatic check_seq(input string name, input logic [W-1:0] base, input int n);
        check({name, "_count"}, 32'(fired.size()), 32'(n));
        for (int i = 0; i < n && i < fired.size(); i++)
            check($sformatf("%s_word%0d", name, i), 32'(fired[i]), 32'(base + W'(i)));
    endtask

    task automatic check_reset(input string name);
        check({name, "_f_rpop"}, 32'(f_rpop), 32'd0);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_out_data"}, 32'(out_data), 32'd0);
        check({name, "_out_cnt"}, 32'(out_cnt), 32'd0);
        check({name, "_idle"}, 32'(idle), 32'd1);
    endtask

    typedef struct { int n; int hold; int exp_pops; } bp_vec_t;
    bp_vec_t bp_tab[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int sent;
        bp_tab[0] = '{n: 1, hold: 8, exp_pops: 1};
        bp_tab[1] = '{n: 2, hold: 8, exp_pops: 2};
        bp_tab[2] = '{n: 3, hold: 8, exp_pops: 3};
        bp_tab[3] = '{n: 8, hold: 8, exp_pops: 3};

        rst_n = 1'b0;
        tick();
        tick();
        chk_en = 1;
        sample();
        check_reset("reset");
        rst_n = 1'b1;
        tick();

        // Throughput with out_ready held high
        clear_log();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wpush = 1'b1;
            wdata = 16'hA000 + 16'(i);
            tick();
        end
        wpush = 1'b0;
        wait_idle("s2", 60);
        check("s2_latency", 32'(first_valid - first_pop), 32'd2);
        check_seq("s2", 16'hA000, 8);
        check("s2_cnt", 32'(out_cnt), 32'd8);

        // Backpressure table
        foreach (bp_tab[r]) begin
            fill(16'hB000 + 16'(r * 16), bp_tab[r].n);
            clear_log();
            flush = 1'b0;
            for (int h = 0; h < bp_tab[r].hold; h++) tick();
            sample();
            check($sformatf("bp%0d_pops", r), 32'(pops), 32'(bp_tab[r].exp_pops));
            check($sformatf("bp%0d_rpop", r), 32'(f_rpop), 32'd0);
            check($sformatf("bp%0d_head", r), 32'(out_data), 32'(16'hB000 + 16'(r * 16)));
            tick();
            out_ready = 1'b1;
            wait_idle($sformatf("bp%0d", r), 60);
            check_seq($sformatf("bp%0d", r), 16'hB000 + 16'(r * 16), bp_tab[r].n);
            check($sformatf("bp%0d_cnt", r), 32'(out_cnt), 32'(bp_tab[r].n));
            tick();
        end

        // Random ready and push gaps
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_log();
        sent = 0;
        for (int g = 0; g < 5000 && sent < 100; g++) begin
            out_ready = 1'($urandom % 2);
            if (($urandom % 3) != 0 && fq.size() < FDEPTH) begin
                wpush = 1'b1;
                wdata = 16'h4000 + 16'(sent);
                sent++;
            end else begin
                wpush = 1'b0;
            end
            tick();
        end
        wpush = 1'b0;
        for (int g = 0; g < 2000; g++) begin
            sample();
            if (idle) break;
            tick();
            out_ready = 1'($urandom % 2);
        end
        check("s4_idle", 32'(idle), 32'd1);
        check_seq("s4", 16'h4000, 100);
        check("s4_cnt", 32'(out_cnt), 32'd100);
        tick();

        // Flush while a word is in flight
        fill(16'hC000, 8);
        clear_log();
        flush = 1'b0;
        tick();
        tick();
        tick();
        flush = 1'b1;
        sample();
        check("s5_pops", 32'(pops), 32'd3);
        tick();
        flush = 1'b0;
        sample();
        check("s5_valid", 32'(out_valid), 32'd0);
        check("s5_cnt", 32'(out_cnt), 32'd0);
        tick();
        fired.delete();
        out_ready = 1'b1;
        wait_idle("s5", 60);
        check_seq("s5", 16'hC003, 5);
        check("s5_cnt_end", 32'(out_cnt), 32'd5);
        tick();

        // Reset in the middle of a run
        fill(16'hD000, 8);
        clear_log();
        flush = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (fired.size() >= 3) break;
            tick();
        end
        check("s6_three_fires", 32'(fired.size()), 32'd3);
        tick();
        rst_n = 1'b0;
        tick();
        sample();
        check_reset("s6_reset");
        check("s6_fifo_empty", 32'(fq.size()), 32'd0);
        tick();
        rst_n = 1'b1;
        clear_log();
        for (int i = 0; i < 8; i++) begin
            wpush = 1'b1;
            wdata = 16'hE000 + 16'(i);
            tick();
        end
        wpush = 1'b0;
        wait_idle("s6", 60);
        check_seq("s6", 16'hE000, 8);
        check("s6_cnt", 32'(out_cnt), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
